// File: rtl/stego_embed_ctrl_pkg.sv
// ============================================================================
// Module  : stego_pkg
// Brief   : Shared state encoding, defaults and sizing helper for the
//           LSB audio embedding controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package stego_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SYNC    = 2'b01,
        ST_PAYLOAD = 2'b10,
        ST_GAP     = 2'b11
    } state_t;

    localparam int          DEF_BPS       = 24;
    localparam logic [7:0]  DEF_SYNC_WORD = 8'hA5;

    // One counter serves all three phases, so it must hold the largest count.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stego_embed_ctrl_if.sv
// ============================================================================
// Module  : stego_embed_ctrl_if
// Brief   : Message and sample stream bundle between source, embedder, sink.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface stego_embed_ctrl_if
    import stego_pkg::*;
#(
    parameter int BPS     = DEF_BPS,
    parameter int MSG_LEN = 88
);
    logic               in_msg_load;
    logic [MSG_LEN-1:0] in_msg;
    logic               in_sample_valid;
    logic [BPS-1:0]     in_sample;
    logic [BPS-1:0]     out_sample;
    logic               out_sample_valid;
    logic               out_busy;
    logic               out_msg_done;
    logic               out_pending;

    modport master (
        output in_msg_load, in_msg, in_sample_valid, in_sample,
        input  out_sample, out_sample_valid, out_busy, out_msg_done, out_pending
    );

    modport slave (
        input  in_msg_load, in_msg, in_sample_valid, in_sample,
        output out_sample, out_sample_valid, out_busy, out_msg_done, out_pending
    );

endinterface

`default_nettype wire

// File: rtl/stego_embed_ctrl_lsb_insert.sv
// ============================================================================
// Module  : lsb_insert
// Brief   : Registered single-sample LSB replacement with valid pass-along.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsb_insert
    import stego_pkg::*;
#(
    parameter int BPS = DEF_BPS
) (
    input  wire logic           in_clk,
    input  wire logic           in_rst,
    input  wire logic [BPS-1:0] in_sample,
    input  wire logic           in_bit,
    input  wire logic           in_embed_en,
    input  wire logic           in_valid,
    output logic      [BPS-1:0] out_sample,
    output logic                out_valid
);

    logic [BPS-1:0] r_sample;
    logic           r_valid;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_sample <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid  <= in_valid;
            r_sample <= in_embed_en ? {in_sample[BPS-1:1], in_bit} : in_sample;
        end
    end

    assign out_sample = r_sample;
    assign out_valid  = r_valid;

endmodule

`default_nettype wire

// File: rtl/stego_embed_ctrl.sv
// ============================================================================
// Module  : stego_embed_ctrl
// Brief   : Frames a message as sync word + payload and embeds one bit per
//           valid audio sample LSB, with gap, repeat and one-deep queueing.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stego_embed_ctrl
    import stego_pkg::*;
#(
    parameter int                  BPS         = DEF_BPS,
    parameter int                  MSG_LEN     = 88,
    parameter int                  SYNC_LEN    = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD   = SYNC_LEN'(DEF_SYNC_WORD),
    parameter int                  GAP_SAMPLES = 16,
    parameter int                  REPEAT      = 1
) (
    input  wire logic         in_clk,
    input  wire logic         in_rst,
    stego_embed_ctrl_if.slave bus
);

    localparam int            CW          = cnt_width(SYNC_LEN, MSG_LEN, GAP_SAMPLES);
    localparam logic [CW-1:0] c_SYNC_LAST = CW'(SYNC_LEN - 1);
    localparam logic [CW-1:0] c_MSG_LAST  = CW'(MSG_LEN - 1);
    localparam logic [CW-1:0] c_GAP_LAST  = CW'((GAP_SAMPLES > 0) ? GAP_SAMPLES - 1 : 0);

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic [MSG_LEN-1:0]  r_active, r_pend_msg, r_pay_sr;
    logic [SYNC_LEN-1:0] r_sync_sr;
    logic                r_pending, r_msg_done;

    logic w_embed, w_bit, w_resolve, w_done;
    logic w_idle_load, w_take_pend, w_start_sync, w_start_pay;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_embed      = 1'b0;
        w_bit        = 1'b0;
        w_resolve    = 1'b0;
        w_done       = 1'b0;
        w_idle_load  = 1'b0;
        w_take_pend  = 1'b0;
        w_start_sync = 1'b0;
        w_start_pay  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_msg_load) begin
                    w_state_nxt  = ST_SYNC;
                    w_cnt_nxt    = '0;
                    w_idle_load  = 1'b1;
                    w_start_sync = 1'b1;
                end
            end
            ST_SYNC: begin
                w_bit = r_sync_sr[SYNC_LEN-1];
                if (bus.in_sample_valid) begin
                    w_embed = 1'b1;
                    if (r_cnt == c_SYNC_LAST) begin
                        w_state_nxt = ST_PAYLOAD;
                        w_cnt_nxt   = '0;
                        w_start_pay = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                w_bit = r_pay_sr[MSG_LEN-1];
                if (bus.in_sample_valid) begin
                    w_embed = 1'b1;
                    if (r_cnt == c_MSG_LAST) begin
                        w_done = 1'b1;
                        if (GAP_SAMPLES > 0) begin
                            w_state_nxt = ST_GAP;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_resolve = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (bus.in_sample_valid) begin
                    if (r_cnt == c_GAP_LAST) w_resolve = 1'b1;
                    else                     w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A queued message outranks repeating the current one.
        if (w_resolve) begin
            w_cnt_nxt = '0;
            if (r_pending) begin
                w_state_nxt  = ST_SYNC;
                w_take_pend  = 1'b1;
                w_start_sync = 1'b1;
            end else if (REPEAT != 0) begin
                w_state_nxt  = ST_SYNC;
                w_start_sync = 1'b1;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // Shift copies keep the active message untouched while bits stream out.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_active   <= '0;
            r_pend_msg <= '0;
            r_pending  <= 1'b0;
            r_sync_sr  <= '0;
            r_pay_sr   <= '0;
            r_msg_done <= 1'b0;
        end else begin
            r_msg_done <= w_done;
            if (w_idle_load)      r_active <= bus.in_msg;
            else if (w_take_pend) r_active <= r_pend_msg;

            if (bus.in_msg_load && (r_state != ST_IDLE)) begin
                r_pending  <= 1'b1;
                r_pend_msg <= bus.in_msg;
            end else if (w_take_pend) begin
                r_pending <= 1'b0;
            end

            if (w_start_sync)                           r_sync_sr <= SYNC_WORD;
            else if (w_embed && (r_state == ST_SYNC))   r_sync_sr <= r_sync_sr << 1;

            if (w_start_pay)                            r_pay_sr <= r_active;
            else if (w_embed && (r_state == ST_PAYLOAD)) r_pay_sr <= r_pay_sr << 1;
        end
    end

    lsb_insert #(
        .BPS(BPS)
    ) u_lsb_insert (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .in_sample   (bus.in_sample),
        .in_bit      (w_bit),
        .in_embed_en (w_embed),
        .in_valid    (bus.in_sample_valid),
        .out_sample  (bus.out_sample),
        .out_valid   (bus.out_sample_valid)
    );

    assign bus.out_busy     = (r_state != ST_IDLE);
    assign bus.out_msg_done = r_msg_done;
    assign bus.out_pending  = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_stego_embed_ctrl.sv
// ============================================================================
// Module  : tb_stego_embed_ctrl
// Brief   : Directed self-checking bench; one instance without and one with
//           message repeat, both sharing the same stimulus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stego_embed_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        drv_load = 1'b0;
    logic [7:0]  drv_msg = '0;
    logic        drv_valid = 1'b0;
    logic [23:0] drv_sample = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    stego_embed_ctrl_if #(.BPS(24), .MSG_LEN(8)) if0 ();
    stego_embed_ctrl_if #(.BPS(24), .MSG_LEN(8)) if1 ();

    assign if0.in_msg_load = drv_load;   assign if1.in_msg_load = drv_load;
    assign if0.in_msg = drv_msg;         assign if1.in_msg = drv_msg;
    assign if0.in_sample_valid = drv_valid; assign if1.in_sample_valid = drv_valid;
    assign if0.in_sample = drv_sample;   assign if1.in_sample = drv_sample;

    stego_embed_ctrl #(.BPS(24), .MSG_LEN(8), .SYNC_LEN(4), .SYNC_WORD(4'b1010),
                       .GAP_SAMPLES(2), .REPEAT(0))
        u_dut0 (.in_clk(clk), .in_rst(rst), .bus(if0.slave));

    stego_embed_ctrl #(.BPS(24), .MSG_LEN(8), .SYNC_LEN(4), .SYNC_WORD(4'b1010),
                       .GAP_SAMPLES(2), .REPEAT(1))
        u_dut1 (.in_clk(clk), .in_rst(rst), .bus(if1.slave));

    // Framed bit k of a message: 4 sync bits 1010 then the payload MSB first.
    function automatic logic fbit(input logic [7:0] m, input int k);
        logic [3:0] s;
        s = 4'b1010;
        if (k < 4) return s[3-k];
        return m[11-k];
    endfunction

    task automatic step(input logic v, input logic [23:0] s, input logic ld, input logic [7:0] m);
        drv_valid = v; drv_sample = s; drv_load = ld; drv_msg = m;
        @(posedge clk);
        #1;
        drv_load = 1'b0;
    endtask

    task automatic do_reset();
        drv_valid = 1'b0; drv_load = 1'b0; drv_sample = '0; drv_msg = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({if0.out_sample, if0.out_sample_valid, if0.out_busy, if0.out_msg_done, if0.out_pending} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sample=%h v=%b busy=%b done=%b pend=%b, want all 0",
                     if0.out_sample, if0.out_sample_valid, if0.out_busy, if0.out_msg_done, if0.out_pending);
        end
        step(1'b1, 24'h55AA33, 1'b0, 8'h00);
        n_checks++;
        if (if0.out_sample !== 24'h55AA33 || if0.out_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_passthrough: got %h busy=%b, want 55aa33 busy=0", if0.out_sample, if0.out_busy);
        end
    endtask

    task automatic test_basic();
        logic [23:0] exp;
        do_reset();
        step(1'b0, 24'h0, 1'b1, 8'hC3);
        n_checks++;
        if (if0.out_busy !== 1'b1 || if0.out_sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_load: got busy=%b v=%b, want busy=1 v=0", if0.out_busy, if0.out_sample_valid);
        end
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 24'hFFFFFE, 1'b0, 8'h00);
            exp = (i < 12) ? {23'h7FFFFF, fbit(8'hC3, i)} : 24'hFFFFFE;
            n_checks++;
            if (if0.out_sample !== exp || if0.out_sample_valid !== 1'b1 || if0.out_msg_done !== (i == 11)) begin
                n_fail++;
                $display("FAIL basic_sample%0d: got %h v=%b done=%b, want %h v=1 done=%b",
                         i, if0.out_sample, if0.out_sample_valid, if0.out_msg_done, exp, (i == 11));
            end
        end
        n_checks++;
        if (if0.out_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got busy=%b, want 0", if0.out_busy);
        end
    endtask

    task automatic test_valid_gaps();
        logic [23:0] exp;
        int          j;
        do_reset();
        step(1'b0, 24'h0, 1'b1, 8'hC3);
        for (int i = 0; i < 28; i++) begin
            j = i / 2;
            if (i % 2 == 0) begin
                step(1'b1, 24'hFFFFFE, 1'b0, 8'h00);
                exp = (j < 12) ? {23'h7FFFFF, fbit(8'hC3, j)} : 24'hFFFFFE;
                n_checks++;
                if (if0.out_sample !== exp || if0.out_sample_valid !== 1'b1 || if0.out_msg_done !== (j == 11)) begin
                    n_fail++;
                    $display("FAIL gaps_valid%0d: got %h v=%b done=%b, want %h v=1 done=%b",
                             j, if0.out_sample, if0.out_sample_valid, if0.out_msg_done, exp, (j == 11));
                end
            end else begin
                step(1'b0, 24'h000000, 1'b0, 8'h00);
                n_checks++;
                if (if0.out_sample_valid !== 1'b0 || if0.out_msg_done !== 1'b0 || if0.out_busy !== (j + 1 < 14)) begin
                    n_fail++;
                    $display("FAIL gaps_hold%0d: got v=%b done=%b busy=%b, want v=0 done=0 busy=%b",
                             j, if0.out_sample_valid, if0.out_msg_done, if0.out_busy, (j + 1 < 14));
                end
            end
        end
    endtask

    task automatic test_repeat();
        logic [23:0] exp;
        int          k;
        do_reset();
        step(1'b0, 24'h0, 1'b1, 8'h81);
        for (int i = 0; i < 28; i++) begin
            k = i % 14;
            step(1'b1, 24'h123457, 1'b0, 8'h00);
            exp = (k < 12) ? {23'h091A2B, fbit(8'h81, k)} : 24'h123457;
            n_checks++;
            if (if1.out_sample !== exp || if1.out_msg_done !== (k == 11) || if1.out_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL repeat_sample%0d: got %h done=%b busy=%b, want %h done=%b busy=1",
                         i, if1.out_sample, if1.out_msg_done, if1.out_busy, exp, (k == 11));
            end
        end
    endtask

    task automatic test_pending();
        logic [23:0] exp;
        logic [7:0]  m;
        do_reset();
        step(1'b0, 24'h0, 1'b1, 8'hFF);
        for (int i = 0; i < 28; i++) begin
            m = (i < 14) ? 8'hFF : 8'h00;
            step(1'b1, 24'hFFFFFE, (i == 5), 8'h00);
            exp = ((i % 14) < 12) ? {23'h7FFFFF, fbit(m, i % 14)} : 24'hFFFFFE;
            n_checks++;
            if (if0.out_sample !== exp || if0.out_pending !== (i >= 5 && i < 13)) begin
                n_fail++;
                $display("FAIL pending_sample%0d: got %h pend=%b, want %h pend=%b",
                         i, if0.out_sample, if0.out_pending, exp, (i >= 5 && i < 13));
            end
        end
        n_checks++;
        if (if0.out_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pending_idle: got busy=%b, want 0", if0.out_busy);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        step(1'b1, 24'hABCDE0, 1'b1, 8'hC3);
        n_checks++;
        if (if0.out_sample !== 24'hABCDE0) begin
            n_fail++;
            $display("FAIL same_cycle_pass: got %h, want abcde0", if0.out_sample);
        end
        step(1'b1, 24'hABCDE0, 1'b0, 8'h00);
        n_checks++;
        if (if0.out_sample !== 24'hABCDE1) begin
            n_fail++;
            $display("FAIL same_cycle_sync: got %h, want abcde1", if0.out_sample);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b0, 24'h0, 1'b1, 8'hC3);
        for (int i = 0; i < 6; i++) step(1'b1, 24'hFFFFFE, (i == 5), 8'h3C);
        n_checks++;
        if (if0.out_busy !== 1'b1 || if0.out_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre: got busy=%b pend=%b, want 1 1", if0.out_busy, if0.out_pending);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({if0.out_sample, if0.out_sample_valid, if0.out_busy, if0.out_msg_done, if0.out_pending} !== 28'd0) begin
            n_fail++;
            $display("FAIL arst_immediate: got sample=%h v=%b busy=%b done=%b pend=%b, want all 0",
                     if0.out_sample, if0.out_sample_valid, if0.out_busy, if0.out_msg_done, if0.out_pending);
        end
        drv_valid = 1'b1; drv_sample = 24'h777777;
        @(posedge clk);
        #1;
        n_checks++;
        if (if0.out_sample_valid !== 1'b0 || if0.out_sample !== 24'h0) begin
            n_fail++;
            $display("FAIL arst_held: got v=%b sample=%h, want 0 0", if0.out_sample_valid, if0.out_sample);
        end
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 24'hFFFFFE ^ 24'(i), 1'b0, 8'h00);
            n_checks++;
            if (if0.out_sample !== (24'hFFFFFE ^ 24'(i)) || if0.out_busy !== 1'b0 || if0.out_pending !== 1'b0) begin
                n_fail++;
                $display("FAIL arst_after%0d: got %h busy=%b pend=%b, want %h busy=0 pend=0",
                         i, if0.out_sample, if0.out_busy, if0.out_pending, 24'hFFFFFE ^ 24'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_valid_gaps();
        test_repeat();
        test_pending();
        test_same_cycle();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stego_embed_ctrl.md
Name: stego_embed_ctrl

Overview:
Sequencer for LSB audio-sample message embedding.
- Accepts a parallel message and a stream of audio samples.
- Frames the message as a sync word followed by payload bits, MSB first.
- Replaces the LSB of one valid sample per framed bit, then inserts an unmodified gap, and either repeats the message, starts a queued message, or returns to idle.
- Sits between the audio sample source (I2S/ADC side) and the sample sink (DAC/storage side).

Parameters:
BPS, 24, bits per sample
MSG_LEN, 88, payload bits per message
SYNC_LEN, 8, sync-word length in bits (>=1)
SYNC_WORD, 8'hA5, sync pattern, width SYNC_LEN, sent MSB first
GAP_SAMPLES, 16, unmodified samples after each payload (0 = no gap)
REPEAT, 1, 1 = re-send the same message after the gap; 0 = go idle

Ports:
in_clk  input  1  clock, all logic on rising edge
in_rst  input  1  asynchronous reset, active-high
in_msg_load  input  1  one-cycle pulse: capture in_msg
in_msg  input  MSG_LEN  message payload, bit MSG_LEN-1 sent first
in_sample_valid  input  1  in_sample is valid this cycle
in_sample  input  BPS  audio sample
out_sample  output  BPS  sample with LSB replaced, or passed through unchanged
out_sample_valid  output  1  registered copy of in_sample_valid
out_busy  output  1  high in SYNC, PAYLOAD and GAP
out_msg_done  output  1  one-cycle pulse, coincides with the output of the last payload sample
out_pending  output  1  a queued message is waiting

Behaviour:
- Reset (async, in_rst=1):
  - State goes to IDLE.
  - All outputs are 0.
  - Message, pending and counter registers are cleared.
  - A message in flight is discarded; samples arriving during reset produce no output.
- Latency: out_sample and out_sample_valid appear exactly 1 cycle after in_sample / in_sample_valid. No backpressure.
- Counters advance only on cycles where in_sample_valid=1. Cycles with in_sample_valid=0 hold all state.
- Bit counter width is $clog2(max(SYNC_LEN, MSG_LEN, GAP_SAMPLES) + 1).
- Embedding rule: out_sample = {in_sample[BPS-1:1], bit}. Passthrough rule: out_sample = in_sample.
- IDLE:
  - Samples pass through unchanged.
  - On in_msg_load: capture in_msg into the active register and move to SYNC.
  - If in_msg_load and in_sample_valid arrive in the same cycle, that sample passes through unchanged; embedding starts on the next valid sample.
- SYNC:
  - Embed SYNC_WORD bits MSB first, one per valid sample.
  - After SYNC_LEN samples, move to PAYLOAD.
- PAYLOAD:
  - Embed active message bits MSB first.
  - On the MSG_LEN-th valid sample: pulse out_msg_done aligned with that output sample.
  - Then move to GAP if GAP_SAMPLES>0, otherwise resolve the next action immediately (see below).
- GAP:
  - Pass GAP_SAMPLES valid samples through unchanged, then resolve the next action.
- Next action, in priority order:
  1. Pending message present: copy it to the active register, clear pending, go to SYNC.
  2. REPEAT=1: go to SYNC with the same message.
  3. Otherwise: go to IDLE.
  - The first sample after resolution is already a SYNC sample; no idle cycle is inserted.
- in_msg_load while busy:
  - Captured into a one-deep pending register; out_pending=1.
  - A second load while pending overwrites it (last wins).
  - The active message is never altered mid-frame.
- in_msg_load in the same cycle as resolution: the new message becomes pending and is used at the next boundary.
- out_busy=0 only in IDLE.

Decomposition:
- Package stego_pkg:
  - state enum (IDLE, SYNC, PAYLOAD, GAP), 2-bit encoding 00/01/10/11
  - default BPS
  - default SYNC_WORD
  - counter-width function
- Sub-module lsb_insert: registered single-sample LSB replacement.
  - Inputs: sample, bit, embed_en, valid.
  - Outputs: out_sample, out_valid.
  - The controller drives embed_en and bit; the FSM, counters and message registers stay in stego_embed_ctrl.

Test Plan:
- Test parameters for all scenarios: BPS=24, SYNC_LEN=4, SYNC_WORD=4'b1010, MSG_LEN=8, GAP_SAMPLES=2.
- Basic frame (REPEAT=0): load 8'hC3, then 14 valid samples of 24'hFFFFFE.
  - Output LSBs: 1,0,1,0,1,1,0,0,0,0,1,1, then two unmodified 24'hFFFFFE.
  - out_msg_done pulses with sample 12; afterwards IDLE, out_busy=0.
- Valid gaps: same as basic, with in_sample_valid=0 on alternate cycles.
  - Identical LSB sequence; state holds on invalid cycles; out_sample_valid mirrors the input delayed by 1.
- Repeat (REPEAT=1): load 8'h81, then 28 valid samples.
  - Sample 15 starts sync 1010 again; out_msg_done pulses at samples 12 and 26.
- Pending: load 8'hFF, then load 8'h00 during PAYLOAD.
  - out_pending=1 until the gap ends; the second frame carries payload LSBs of all 0; the first frame is unaltered.
- Same-cycle load and sample in IDLE: that sample's output equals its input; the next sample carries sync bit 1.
- Reset mid-PAYLOAD: assert in_rst asynchronously (between clock edges).
  - All outputs are 0 immediately.
  - After release, samples pass through unchanged until a new load.
